// File: rtl/lane_tx_arbiter_if.sv
// Bundle between the two requester FIFOs, the serializer lane and the arbiter.
// The arbiter sits on the slave side; the FIFO/lane environment on the master side.
interface lane_tx_arbiter_if;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic [7:0] fifo_data_0;
    logic [7:0] fifo_data_1;
    logic       tx_ready;
    logic       pop_0;
    logic       pop_1;
    logic       valid_out;
    logic [7:0] data_out;
    logic [1:0] grant;
    logic       sync_done;

    modport master (
        output fifo_empty_0,
        output fifo_empty_1,
        output fifo_data_0,
        output fifo_data_1,
        output tx_ready,
        input  pop_0,
        input  pop_1,
        input  valid_out,
        input  data_out,
        input  grant,
        input  sync_done
    );

    modport slave (
        input  fifo_empty_0,
        input  fifo_empty_1,
        input  fifo_data_0,
        input  fifo_data_1,
        input  tx_ready,
        output pop_0,
        output pop_1,
        output valid_out,
        output data_out,
        output grant,
        output sync_done
    );
endinterface

// File: rtl/lane_tx_arbiter.sv
// Two-requester round-robin byte arbiter feeding a serializer lane. Sends idle symbols
// until the lane has been ready for SYNC_CYCLES consecutive cycles, then bursts bytes.
module lane_tx_arbiter #(
    parameter int unsigned SYNC_CYCLES = 4,
    parameter int unsigned BURST_MAX   = 4
) (
    input  logic             clk_4f,
    input  logic             reset,
    lane_tx_arbiter_if.slave bus
);

    localparam int unsigned SyncW  = $clog2(SYNC_CYCLES + 1);
    localparam int unsigned BurstW = $clog2(BURST_MAX + 1);

    localparam logic [SyncW-1:0]  SyncLast  = SyncW'(SYNC_CYCLES - 1);
    localparam logic [BurstW-1:0] BurstLast = BurstW'(BURST_MAX - 1);
    localparam logic [BurstW-1:0] BurstTop  = BurstW'(BURST_MAX);
    localparam logic [7:0]        IdleSym   = 8'hBC;

    typedef enum logic [1:0] {
        StSync,
        StIdle,
        StServe0,
        StServe1
    } state_e;

    state_e             state_q, state_d;
    logic [SyncW-1:0]   sync_cnt_q, sync_cnt_d;
    logic [BurstW-1:0]  burst_q, burst_d;
    logic               rr_q, rr_d;
    logic               valid_q, valid_d;
    logic [7:0]         data_q, data_d;
    logic               sync_done_q, sync_done_d;

    logic               pop0, pop1;
    logic               serve_sel;
    logic               head_empty;
    logic               head_pop;
    logic [7:0]         head_data;

    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        burst_d     = burst_q;
        rr_d        = rr_q;
        sync_done_d = sync_done_q;
        valid_d     = 1'b0;
        data_d      = IdleSym;
        pop0        = 1'b0;
        pop1        = 1'b0;
        serve_sel   = 1'b0;
        head_empty  = 1'b1;
        head_pop    = 1'b0;
        head_data   = 8'h00;

        unique case (state_q)
            StSync: begin
                if (!bus.tx_ready) begin
                    sync_cnt_d = '0;
                end else begin
                    sync_cnt_d = sync_cnt_q + SyncW'(1);
                    if (sync_cnt_q == SyncLast) begin
                        state_d     = StIdle;
                        sync_done_d = 1'b1;
                    end
                end
            end

            StIdle: begin
                // rr_q == 0 favours requester 0 when both are waiting
                if (!bus.fifo_empty_0 && (bus.fifo_empty_1 || !rr_q)) begin
                    state_d = StServe0;
                end else if (!bus.fifo_empty_1) begin
                    state_d = StServe1;
                end
            end

            StServe0, StServe1: begin
                serve_sel  = (state_q == StServe1);
                head_empty = serve_sel ? bus.fifo_empty_1 : bus.fifo_empty_0;
                head_data  = serve_sel ? bus.fifo_data_1 : bus.fifo_data_0;
                head_pop   = !head_empty && bus.tx_ready;
                pop0       = head_pop && !serve_sel;
                pop1       = head_pop && serve_sel;

                if (head_pop) begin
                    valid_d = 1'b1;
                    data_d  = head_data;
                    burst_d = burst_q + BurstW'(1);
                end

                // Leave on a full burst or on a drained FIFO seen while the lane is live
                if ((head_pop && (burst_q == BurstLast)) || (head_empty && bus.tx_ready)) begin
                    state_d = StIdle;
                    rr_d    = !serve_sel;
                    burst_d = '0;
                end
            end

            default: begin
                state_d = StSync;
            end
        endcase
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q     <= StSync;
            sync_cnt_q  <= '0;
            burst_q     <= '0;
            rr_q        <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= 8'h00;
            sync_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            burst_q     <= burst_d;
            rr_q        <= rr_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            sync_done_q <= sync_done_d;
        end
    end

    assign bus.pop_0     = pop0;
    assign bus.pop_1     = pop1;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.sync_done = sync_done_q;
    assign bus.grant     = {state_q == StServe1, state_q == StServe0};

    a_pop_exclusive : assert property (
        @(posedge clk_4f) disable iff (!reset) !(bus.pop_0 && bus.pop_1));
    a_pop0_legal : assert property (
        @(posedge clk_4f) disable iff (!reset) bus.pop_0 |-> (!bus.fifo_empty_0 && bus.tx_ready));
    a_pop1_legal : assert property (
        @(posedge clk_4f) disable iff (!reset) bus.pop_1 |-> (!bus.fifo_empty_1 && bus.tx_ready));
    a_burst_bound : assert property (
        @(posedge clk_4f) disable iff (!reset) burst_q <= BurstTop);
    a_sync_sticky : assert property (
        @(posedge clk_4f) disable iff (!reset) sync_done_q |=> sync_done_q);

endmodule

// File: tb/tb_lane_tx_arbiter.sv
// Directed bench for lane_tx_arbiter: show-ahead FIFO models as queues, expected
// grant/valid/data per clock edge written out by hand.
module tb_lane_tx_arbiter;

    logic clk_4f = 1'b0;
    logic reset;

    lane_tx_arbiter_if bus ();

    lane_tx_arbiter #(
        .SYNC_CYCLES(4),
        .BURST_MAX  (4)
    ) dut (
        .clk_4f(clk_4f),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_4f = ~clk_4f;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int n_vec = 0;
    int n_err = 0;

    // {grant, valid, data} after each edge of the two-requester round-robin run
    logic [10:0] rr_tab [18] = '{
        {2'b01, 1'b0, 8'hBC}, {2'b01, 1'b1, 8'h01}, {2'b01, 1'b1, 8'h02},
        {2'b01, 1'b1, 8'h03}, {2'b00, 1'b1, 8'h04}, {2'b10, 1'b0, 8'hBC},
        {2'b10, 1'b1, 8'h11}, {2'b10, 1'b1, 8'h12}, {2'b10, 1'b1, 8'h13},
        {2'b00, 1'b1, 8'h14}, {2'b01, 1'b0, 8'hBC}, {2'b01, 1'b1, 8'h05},
        {2'b01, 1'b1, 8'h06}, {2'b00, 1'b0, 8'hBC}, {2'b10, 1'b0, 8'hBC},
        {2'b10, 1'b1, 8'h15}, {2'b10, 1'b1, 8'h16}, {2'b00, 1'b0, 8'hBC}
    };

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifos();
        bus.fifo_empty_0 = (q0.size() == 0);
        bus.fifo_empty_1 = (q1.size() == 0);
        bus.fifo_data_0  = 8'h00;
        bus.fifo_data_1  = 8'h00;
        if (q0.size() > 0) bus.fifo_data_0 = q0[0];
        if (q1.size() > 0) bus.fifo_data_1 = q1[0];
    endtask

    // Advance exactly one rising edge; pops seen before the edge retire the FIFO head.
    task automatic tick();
        logic p0;
        logic p1;
        @(negedge clk_4f);
        p0 = bus.pop_0;
        p1 = bus.pop_1;
        @(posedge clk_4f);
        #1;
        if (p0 && q0.size() > 0) q0.delete(0);
        if (p1 && q1.size() > 0) q1.delete(0);
        drive_fifos();
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [1:0] g, input logic v,
                            input logic [7:0] d);
        tick();
        check_eq($sformatf("%s.grant", tag), bus.grant, g);
        check_eq($sformatf("%s.valid", tag), bus.valid_out, v);
        check_eq($sformatf("%s.data", tag), bus.data_out, d);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq($sformatf("%s.valid", tag), bus.valid_out, 0);
        check_eq($sformatf("%s.data", tag), bus.data_out, 8'h00);
        check_eq($sformatf("%s.sync_done", tag), bus.sync_done, 0);
        check_eq($sformatf("%s.grant", tag), bus.grant, 2'b00);
        check_eq($sformatf("%s.pop0", tag), bus.pop_0, 0);
        check_eq($sformatf("%s.pop1", tag), bus.pop_1, 0);
    endtask

    initial begin
        reset        = 1'b0;
        bus.tx_ready = 1'b1;
        q0.push_back(8'h11);
        q1.push_back(8'h22);
        drive_fifos();
        #2;
        check_reset_outputs("rst");

        // Release between edges so each tick is one counted edge
        @(posedge clk_4f);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            check_eq($sformatf("sync%0d.pop0", i), bus.pop_0, 0);
            check_eq($sformatf("sync%0d.pop1", i), bus.pop_1, 0);
            tick();
            check_eq($sformatf("sync%0d.done", i), bus.sync_done, (i == 4));
            check_eq($sformatf("sync%0d.valid", i), bus.valid_out, 0);
            check_eq($sformatf("sync%0d.data", i), bus.data_out, 8'hBC);
        end
        check_eq("idle.grant", bus.grant, 2'b00);
        check_eq("idle.pop0", bus.pop_0, 0);
        q0.delete();
        q1.delete();
        drive_fifos();
        #1;

        // Single requester, three bytes
        q0.push_back(8'hAB);
        q0.push_back(8'hCA);
        q0.push_back(8'h12);
        drive_fifos();
        #1;
        step_chk("s1.enter", 2'b01, 1'b0, 8'hBC);
        check_eq("s1.pop0", bus.pop_0, 1);
        check_eq("s1.pop1", bus.pop_1, 0);
        step_chk("s1.b0", 2'b01, 1'b1, 8'hAB);
        step_chk("s1.b1", 2'b01, 1'b1, 8'hCA);
        step_chk("s1.b2", 2'b01, 1'b1, 8'h12);
        check_eq("s1.drained_pop0", bus.pop_0, 0);
        step_chk("s1.exit", 2'b00, 1'b0, 8'hBC);

        // Requester 1 alone wins although the pointer favours it; pointer returns to 0
        q1.push_back(8'h7E);
        drive_fifos();
        #1;
        step_chk("s2.enter", 2'b10, 1'b0, 8'hBC);
        step_chk("s2.b0", 2'b10, 1'b1, 8'h7E);
        step_chk("s2.exit", 2'b00, 1'b0, 8'hBC);

        // Both FIFOs hold six bytes: 4 / 4 / 2 / 2 bursts alternating
        for (int i = 0; i < 6; i++) begin
            q0.push_back(8'(i + 1));
            q1.push_back(8'(i + 8'h11));
        end
        drive_fifos();
        #1;
        for (int i = 0; i < 18; i++) begin
            step_chk($sformatf("rr%0d", i), rr_tab[i][10:9], rr_tab[i][8], rr_tab[i][7:0]);
        end

        // Backpressure for two cycles mid-burst; the burst still ends after 4 bytes
        for (int i = 0; i < 6; i++) q0.push_back(8'(i + 8'h21));
        drive_fifos();
        #1;
        step_chk("bp.enter", 2'b01, 1'b0, 8'hBC);
        step_chk("bp.b0", 2'b01, 1'b1, 8'h21);
        step_chk("bp.b1", 2'b01, 1'b1, 8'h22);
        bus.tx_ready = 1'b0;
        #1;
        check_eq("bp.stall_pop0", bus.pop_0, 0);
        step_chk("bp.hold0", 2'b01, 1'b0, 8'hBC);
        step_chk("bp.hold1", 2'b01, 1'b0, 8'hBC);
        bus.tx_ready = 1'b1;
        #1;
        check_eq("bp.resume_pop0", bus.pop_0, 1);
        step_chk("bp.b2", 2'b01, 1'b1, 8'h23);
        step_chk("bp.b3", 2'b00, 1'b1, 8'h24);
        step_chk("bp.reenter", 2'b01, 1'b0, 8'hBC);
        step_chk("bp.b4", 2'b01, 1'b1, 8'h25);
        step_chk("bp.b5", 2'b01, 1'b1, 8'h26);
        step_chk("bp.exit", 2'b00, 1'b0, 8'hBC);

        // Reset after the second pop of a burst
        for (int i = 0; i < 6; i++) q1.push_back(8'(i + 8'h31));
        drive_fifos();
        #1;
        step_chk("mr.enter", 2'b10, 1'b0, 8'hBC);
        step_chk("mr.b0", 2'b10, 1'b1, 8'h31);
        step_chk("mr.b1", 2'b10, 1'b1, 8'h32);
        reset = 1'b0;
        #1;
        check_reset_outputs("mr.async");
        tick();
        check_eq("mr.fifo_left", q1.size(), 4);
        check_eq("mr.held_pop1", bus.pop_1, 0);
        reset = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            check_eq($sformatf("mr.sync%0d.pop1", i), bus.pop_1, 0);
            tick();
            check_eq($sformatf("mr.sync%0d.done", i), bus.sync_done, (i == 4));
            check_eq($sformatf("mr.sync%0d.grant", i), bus.grant, 2'b00);
        end
        step_chk("mr.enter2", 2'b10, 1'b0, 8'hBC);
        step_chk("mr.b2", 2'b10, 1'b1, 8'h33);

        // Lane drops after two sync cycles; four fresh ready cycles are needed
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
        #1;
        tick();
        check_eq("si.r1", bus.sync_done, 0);
        tick();
        check_eq("si.r2", bus.sync_done, 0);
        bus.tx_ready = 1'b0;
        tick();
        check_eq("si.drop", bus.sync_done, 0);
        bus.tx_ready = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            check_eq($sformatf("si.again%0d.pop1", i), bus.pop_1, 0);
            tick();
            check_eq($sformatf("si.again%0d.done", i), bus.sync_done, (i == 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lane_tx_arbiter.md
LANE_TX_ARBITER -- requirements
Module: lane_tx_arbiter

Interface
REQ-001 Parameter: SYNC_CYCLES, default 4, number of consecutive idle-symbol cycles required before data may be sent.
REQ-002 Parameter: BURST_MAX, default 4, maximum bytes granted to one requester per grant.
REQ-003 Port: clk_4f  in  1  byte clock; the single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: fifo_empty_0 / fifo_empty_1  in  1 each  requester FIFO empty flag.
REQ-006 Port: fifo_data_0 / fifo_data_1  in  8 each  show-ahead FIFO head byte, valid while the FIFO is not empty.
REQ-007 Port: tx_ready  in  1  downstream serializer lane enabled.
REQ-008 Port: pop_0 / pop_1  out  1 each  combinational pop strobe to the requester FIFO.
REQ-009 Port: valid_out  out  1  registered; data_out carries payload.
REQ-010 Port: data_out  out  8  registered byte sent to the parallel-to-serial lane.
REQ-011 Port: grant  out  2  one-hot requester currently served; 2'b00 when none.
REQ-012 Port: sync_done  out  1  registered; high once the SYNC phase has completed.

Function
REQ-013 The FSM SHALL have states SYNC, IDLE, SERVE0 and SERVE1, and SHALL enter SYNC on reset.
REQ-014 SYNC: the block SHALL count cycles with tx_ready=1, clear the count on any cycle with tx_ready=0, and move to IDLE with sync_done<=1 on the edge where the count reaches SYNC_CYCLES.
REQ-015 SYNC: pop_0 and pop_1 SHALL be 0 regardless of FIFO state.
REQ-016 IDLE: if at least one FIFO is non-empty, the FSM SHALL move to SERVE0 or SERVE1 on the next edge; the choice SHALL use the round-robin pointer when both are non-empty, otherwise the only non-empty requester.
REQ-017 IDLE -> SERVEx SHALL take exactly one cycle, and no pop SHALL occur in IDLE.
REQ-018 SERVEx: pop_x SHALL equal (!fifo_empty_x && tx_ready); the other pop SHALL be 0.
REQ-019 On each edge where pop_x=1: data_out <= fifo_data_x, valid_out <= 1, and the burst counter SHALL increment.
REQ-020 On every other edge after SYNC completes: valid_out <= 0 and data_out <= 8'hBC (idle/COM symbol); latency from pop to data_out SHALL be exactly 1 cycle.
REQ-021 SERVEx SHALL exit to IDLE when the burst counter reaches BURST_MAX after a pop, or when fifo_empty_x=1 is sampled with tx_ready=1.
REQ-022 On exit from SERVEx, the round-robin pointer SHALL point to the other requester, and the burst counter SHALL be cleared.
REQ-023 tx_ready=0 in SERVEx SHALL hold the state and burst counter with no pop; valid_out <= 0 and data_out <= 8'hBC.
REQ-024 grant SHALL be 2'b01 in SERVE0, 2'b10 in SERVE1, and 2'b00 otherwise.
REQ-025 sync_done, once set, SHALL remain 1 until reset.
REQ-026 The burst counter width SHALL hold BURST_MAX without wrap, and SHALL never exceed BURST_MAX.

Reset
REQ-027 While reset=0: state=SYNC, sync count=0, burst counter=0, RR pointer=requester 0, valid_out=0, data_out=8'h00, sync_done=0, grant=2'b00, pop_0=pop_1=0.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately with no further pops; after release, the block SHALL redo the full SYNC phase.

Verification
REQ-029 Sync: release reset, tx_ready=1, FIFOs non-empty -> no pop for 4 cycles; data_out=8'hBC, valid_out=0; sync_done=1 after the 4th edge.
REQ-030 Single requester: FIFO0 holds AB,CA,12 -> pop_0 for 3 cycles; data_out AB,CA,12 with valid_out=1, one cycle after each pop; then IDLE, data_out=BC.
REQ-031 Burst/round-robin: both FIFOs hold 6 bytes -> grant 01 for 4 pops, IDLE 1 cycle, grant 10 for 4 pops, IDLE, then grant 01 for the remaining 2.
REQ-032 Backpressure: tx_ready=0 for 2 cycles mid-burst -> no pop, valid_out=0, data_out=BC; the burst resumes and the burst count still totals 4.
REQ-033 SYNC interrupt: tx_ready drops after 2 sync cycles -> the count restarts, and sync_done rises only after 4 further consecutive ready cycles.
REQ-034 Reset mid-burst: reset=0 after the 2nd pop -> outputs return to reset values asynchronously; after release, the 4-cycle SYNC repeats before any pop.
